// File: rtl/keccak_block_loader.sv
// keccak_block_loader: packs a byte-length message word stream into SHA-3/SHAKE padded rate blocks.
module keccak_block_loader #(
  parameter int W = 64,
  parameter int MAX_RATE = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [31:0]         cfg_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [MAX_RATE-1:0] blk_data,
  output logic                blk_last,
  output logic [1:0]          blk_mode
);
  localparam int NB = W / 8;
  typedef enum logic [1:0] {IDLE, LOAD, PAD, HOLD} state_t;
  state_t state, state_n;
  logic [1:0] mode;
  logic [31:0] rem, rem_n, rate;
  logic [5:0] widx, nwords;
  logic [MAX_RATE-1:0] blk, blk_n, end_pad;
  logic last, wr, fin, sfx_now;
  logic [7:0] sfx;
  logic [W-1:0] sw, wd;
  // last marks that the suffix byte is already in this block, so it is the final one
  always_comb begin
    rate = mode == 2'b10 ? 32'd1344 : mode == 2'b01 ? 32'd576 : 32'd1088;
    sfx = mode[1] ? 8'h1F : 8'h06;
    nwords = 6'(rate / W);
    fin = widx == nwords - 6'd1;
    wr = (state == LOAD && in_valid) || state == PAD;
    sfx_now = state == PAD ? !last : state == LOAD && rem < 32'(NB);
    rem_n = rem - (rem < 32'(NB) ? rem : 32'(NB));
    end_pad = MAX_RATE'(8'h80) << (rate - 32'd8);
    sw = '0;
    wd = '0;
    for (int k = 0; k < NB; k++) begin
      sw[8*k +: 8] = in_data[W-1-8*k -: 8];
      wd[8*k +: 8] = state == PAD ? (k == 0 && !last ? sfx : 8'h00) :
                     32'(k) < rem ? sw[8*k +: 8] : 32'(k) == rem ? sfx : 8'h00;
    end
    blk_n = blk;
    blk_n[widx*W +: W] = wd;
    blk_n = blk_n ^ (fin && (last || sfx_now) ? end_pad : '0);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cfg_valid) state_n = cfg_len == 32'd0 ? PAD : LOAD;
      LOAD: if (in_valid) state_n = fin ? HOLD : rem_n == 32'd0 ? PAD : LOAD;
      PAD:  state_n = fin ? HOLD : PAD;
      HOLD: if (blk_ready) state_n = last ? IDLE : rem == 32'd0 ? PAD : LOAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode <= 2'b00;
      rem <= '0;
      widx <= '0;
      blk <= '0;
      last <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && cfg_valid) begin
        mode <= cfg_mode;
        rem <= cfg_len;
      end
      if (wr) begin
        blk <= blk_n;
        widx <= widx + 6'd1;
        last <= last | sfx_now;
      end
      if (state == LOAD && in_valid) rem <= rem_n;
      if (state == HOLD && blk_ready) begin
        blk <= '0;
        widx <= '0;
        last <= 1'b0;
      end
    end
  end
  assign cfg_ready = state == IDLE;
  assign in_ready = state == LOAD;
  assign blk_valid = state == HOLD;
  assign blk_data = blk;
  assign blk_last = last && state == HOLD;
  assign blk_mode = mode;
endmodule

// File: tb/tb_keccak_block_loader.sv
// tb_keccak_block_loader: scoreboard bench comparing emitted blocks against a sponge padding model.
module tb_keccak_block_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, sel, cfg_valid, in_valid, blk_ready;
  logic [1:0] cfg_mode;
  logic [31:0] cfg_len;
  logic [63:0] in_d64;
  logic [31:0] in_d32;
  logic cr64, ir64, bv64, bl64, cr32, ir32, bv32, bl32;
  logic [1:0] bm64, bm32;
  logic [1343:0] bd64, bd32;
  logic cr, ir, bv, bl;
  logic [1:0] bm;
  logic [1343:0] bd;
  assign cr = sel ? cr32 : cr64;
  assign ir = sel ? ir32 : ir64;
  assign bv = sel ? bv32 : bv64;
  assign bl = sel ? bl32 : bl64;
  assign bm = sel ? bm32 : bm64;
  assign bd = sel ? bd32 : bd64;

  keccak_block_loader u64 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid & !sel), .cfg_ready(cr64),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .in_valid(in_valid & !sel), .in_ready(ir64),
    .in_data(in_d64), .blk_valid(bv64), .blk_ready(blk_ready), .blk_data(bd64),
    .blk_last(bl64), .blk_mode(bm64));
  keccak_block_loader #(.W(32)) u32 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid & sel), .cfg_ready(cr32),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .in_valid(in_valid & sel), .in_ready(ir32),
    .in_data(in_d32), .blk_valid(bv32), .blk_ready(blk_ready), .blk_data(bd32),
    .blk_last(bl32), .blk_mode(bm32));

  typedef struct {
    logic [1343:0] d;
    logic l;
    logic [1:0] m;
  } blk_t;
  blk_t q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] msg [0:511];

  function automatic int rate_bytes(input logic [1:0] m);
    return m == 2'b10 ? 168 : m == 2'b01 ? 72 : 136;
  endfunction

  // Standard sponge padding: suffix right after the message, 0x80 in the last rate byte
  task automatic push_model(input logic [1:0] m, input int len);
    int rb = rate_bytes(m);
    int nblk = len / rb + 1;
    blk_t b;
    logic [7:0] v;
    for (int i = 0; i < nblk; i++) begin
      b.d = '0;
      b.l = (i == nblk - 1);
      b.m = m;
      for (int j = 0; j < rb; j++) begin
        int p = i * rb + j;
        v = p < len ? msg[p] : p == len ? (m[1] ? 8'h1F : 8'h06) : 8'h00;
        if (i == nblk - 1 && j == rb - 1) v = v ^ 8'h80;
        b.d[8*j +: 8] = v;
      end
      q.push_back(b);
    end
  endtask

  task automatic run_msg(input logic [1:0] m, input int len, input int stall, input bit s,
                         output int lat, output int words);
    int nb = s ? 4 : 8;
    int nw = (len + nb - 1) / nb;
    int held = 0;
    int cyc = 0;
    logic [1343:0] snap;
    logic [63:0] w;
    blk_t e;
    sel = s;
    lat = -1;
    words = 0;
    push_model(m, len);
    @(negedge clk);
    checks++;
    if (cr !== 1'b1) begin errors++; $display("FAIL cfg_ready_idle got %b want 1", cr); end
    cfg_valid = 1'b1;
    cfg_mode = m;
    cfg_len = len;
    @(negedge clk);
    cfg_valid = 1'b0;
    while (q.size() > 0 && cyc < 3000) begin
      if (ir && words < nw) begin
        w = '1;
        for (int k = 0; k < nb; k++)
          if (words * nb + k < len) w[63-8*k -: 8] = msg[words*nb+k];
        in_d64 = w;
        in_d32 = w[63:32];
        in_valid = 1'b1;
        words++;
      end else in_valid = 1'b0;
      if (bv) begin
        if (lat < 0) lat = cyc;
        if (held < stall) begin
          if (held == 0) snap = bd;
          else begin
            checks += 2;
            if (bd !== snap) begin errors++; $display("FAIL hold_data changed during stall"); end
            if (ir !== 1'b0) begin errors++; $display("FAIL hold_in_ready got %b want 0", ir); end
          end
          blk_ready = 1'b0;
          held++;
        end else begin
          e = q.pop_front();
          checks += 3;
          if (bd !== e.d) begin errors++; $display("FAIL blk_data got %h want %h", bd, e.d); end
          if (bl !== e.l) begin errors++; $display("FAIL blk_last got %b want %b", bl, e.l); end
          if (bm !== e.m) begin errors++; $display("FAIL blk_mode got %b want %b", bm, e.m); end
          blk_ready = 1'b1;
          held = 0;
        end
      end else blk_ready = 1'b0;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    blk_ready = 1'b0;
    checks += 3;
    if (q.size() != 0) begin errors++; $display("FAIL timeout blocks_left %0d want 0", q.size()); end
    q.delete();
    if (words != nw) begin errors++; $display("FAIL words_consumed got %0d want %0d", words, nw); end
    if (cr !== 1'b1) begin errors++; $display("FAIL idle_after got %b want 1", cr); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b0;
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    blk_ready = 1'b0;
    cfg_mode = 2'b00;
    cfg_len = '0;
    in_d64 = '0;
    in_d32 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks += 7;
    if (cr64 !== 1'b1 || cr32 !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready got %b%b want 11", cr64, cr32); end
    if (ir64 !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", ir64); end
    if (bv64 !== 1'b0) begin errors++; $display("FAIL rst_blk_valid got %b want 0", bv64); end
    if (bl64 !== 1'b0) begin errors++; $display("FAIL rst_blk_last got %b want 0", bl64); end
    if (bm64 !== 2'b00) begin errors++; $display("FAIL rst_blk_mode got %b want 0", bm64); end
    if (bd64 !== '0) begin errors++; $display("FAIL rst_blk_data nonzero"); end
    if (bd32 !== '0) begin errors++; $display("FAIL rst_blk_data32 nonzero"); end
  endtask

  task automatic test_len0();
    int lat, words;
    run_msg(2'b10, 0, 0, 1'b0, lat, words);
    checks++;
    if (lat != 21) begin errors++; $display("FAIL len0_latency got %0d want 21", lat); end
  endtask

  task automatic test_short();
    int lat, words;
    msg[0] = 8'h61;
    msg[1] = 8'h62;
    msg[2] = 8'h63;
    run_msg(2'b00, 3, 0, 1'b0, lat, words);
  endtask

  task automatic test_boundary();
    int lat, words;
    for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
    run_msg(2'b11, 136, 0, 1'b0, lat, words);
  endtask

  task automatic test_w32();
    int lat, words;
    for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
    run_msg(2'b01, 71, 0, 1'b1, lat, words);
    checks++;
    if (words != 18) begin errors++; $display("FAIL w32_words got %0d want 18", words); end
  endtask

  task automatic test_stall();
    int lat, words;
    for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
    run_msg(2'b00, 50, 11, 1'b0, lat, words);
  endtask

  task automatic test_mid_reset();
    int lat, words;
    sel = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_mode = 2'b10;
    cfg_len = 100;
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid = 1'b1;
    in_d64 = 64'h0123_4567_89ab_cdef;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (bv64 !== 1'b0) begin errors++; $display("FAIL midrst_blk_valid got %b want 0", bv64); end
    if (ir64 !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", ir64); end
    if (bd64 !== '0) begin errors++; $display("FAIL midrst_blk_data nonzero"); end
    msg[0] = 8'h61;
    msg[1] = 8'h62;
    msg[2] = 8'h63;
    run_msg(2'b00, 3, 0, 1'b0, lat, words);
  endtask

  task automatic test_back_to_back();
    int lat, words;
    for (int i = 0; i < 512; i++) msg[i] = 8'($urandom);
    run_msg(2'b10, 168, 0, 1'b0, lat, words);
    run_msg(2'b00, 272, 0, 1'b0, lat, words);
    run_msg(2'b01, 5, 0, 1'b0, lat, words);
    run_msg(2'b11, 300, 2, 1'b0, lat, words);
    run_msg(2'b00, 17, 0, 1'b1, lat, words);
    run_msg(2'b10, 0, 0, 1'b1, lat, words);
    run_msg(2'b11, 136, 0, 1'b1, lat, words);
  endtask

  initial begin
    test_reset();
    test_len0();
    test_short();
    test_boundary();
    test_w32();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/keccak_block_loader.md
KECCAK_BLOCK_LOADER -- requirements
Module: keccak_block_loader

Interface
REQ-001 SHALL have parameter W, default 64, meaning input word width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter MAX_RATE, default 1344, meaning output block width in bits (largest supported rate).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1  new message descriptor offered.
REQ-006 SHALL have port cfg_ready  output  1  descriptor accepted when both high.
REQ-007 SHALL have port cfg_mode  input  2  00 SHA3-256, 01 SHA3-512, 10 SHAKE128, 11 SHAKE256.
REQ-008 SHALL have port cfg_len  input  32  message length in bytes.
REQ-009 SHALL have port in_valid / in_ready / in_data  input / output / W  message word stream.
REQ-010 SHALL have port blk_valid / blk_ready  output / input  1 each  padded block handshake.
REQ-011 SHALL have port blk_data  output  MAX_RATE  padded rate block.
REQ-012 SHALL have ports blk_last (1) and blk_mode (2)  output  final block of message; mode of message.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, PAD, HOLD; reset state IDLE.
REQ-014 SHALL assert cfg_ready only in IDLE; descriptor accepted when cfg_valid and cfg_ready are high, then latch mode and length and go to LOAD, or go to PAD if cfg_len=0.
REQ-015 SHALL use rate and suffix per mode: 00 1088 bits/0x06, 01 576/0x06, 10 1344/0x1F, 11 1088/0x1F; block holds rate/W words.
REQ-016 SHALL assert in_ready only in LOAD; accept at most one word per cycle on in_valid&&in_ready.
REQ-017 SHALL take message byte k of a word from in_data[W-1-8k -: 8] and place message byte n of the block at blk_data[8n+7:8n].
REQ-018 SHALL track remaining bytes in a 32-bit down-counter, decremented by min(W/8, remaining), never below 0.
REQ-019 SHALL zero word bytes beyond the message end; the byte at message end position in the block SHALL be XORed with suffix.
REQ-020 SHALL go LOAD->PAD when remaining reaches 0 mid-block; PAD fills one zero/pad word per cycle without consuming input.
REQ-021 SHALL XOR 0x80 into byte rate/8-1 of the final block; single-byte pad yields 0x86 or 0x9F.
REQ-022 SHALL go to HOLD the cycle after the block's last word is written (LOAD or PAD); blk_valid=1 only in HOLD.
REQ-023 SHALL hold blk_data, blk_last, blk_mode stable while blk_valid=1 and blk_ready=0.
REQ-024 SHALL, on blk_valid&&blk_ready, go to IDLE if blk_last else LOAD, and clear word counter and block register.
REQ-025 SHALL, when message ends exactly on a block boundary, set blk_last=0 for that block and emit an extra all-pad block with blk_last=1.
REQ-026 SHALL drive blk_data bits at and above the mode rate to zero.
REQ-027 SHALL ignore cfg_valid outside IDLE and in_valid outside LOAD.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE, clear counters and block register; blk_valid=0, in_ready=0, blk_last=0, blk_mode=0, blk_data=0; cfg_ready=1 after reset deasserts.
REQ-029 SHALL discard any partially loaded or held message on reset mid-operation; no block is emitted from it.

Verification
REQ-030 SHALL pass: W=64, mode 10, len 0 -> after 21 PAD cycles one block, byte0=0x1F, byte167=0x80, rest 0, blk_last=1.
REQ-031 SHALL pass: mode 00, len 3, word 0x616263FFFFFFFFFF -> bytes 61 62 63 06, byte135=0x80, other bytes 0, blk_last=1.
REQ-032 SHALL pass: mode 11, len 136 -> block 1 is raw data with blk_last=0; block 2 has byte0=0x1F, byte135=0x80, blk_last=1.
REQ-033 SHALL pass: mode 01, len 71, W=32 -> one block, byte71=0x86, 18 words accepted.
REQ-034 SHALL pass: blk_ready held low 10 cycles in HOLD -> blk_data unchanged, in_ready=0, no input consumed.
REQ-035 SHALL pass: rst pulsed mid-LOAD, then new 3-byte SHA3-256 message -> only the new message's block appears, matching REQ-031.
